// File: rtl/uart_line_editor_pkg.sv
// Shared character codes and editor state encoding for the UART line editor.
package uart_line_editor_pkg;

    localparam logic [7:0] CHAR_BS  = 8'h08;
    localparam logic [7:0] CHAR_DEL = 8'h7F;
    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_SP  = 8'h20;
    localparam logic [7:0] CHAR_BEL = 8'h07;

    typedef enum logic [2:0] {
        ST_EDIT,
        ST_ECHO,
        ST_ECHO_BS1,
        ST_ECHO_BS2,
        ST_ECHO_BS3,
        ST_ECHO_CR,
        ST_ECHO_LF,
        ST_DUMP
    } state_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/uart_line_ram.sv
// Line buffer: simple dual-port RAM, one write port, one read port with registered read.
// Read data holds its value while rd_en_i is low, which the dump path relies on under backpressure.
module uart_line_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_dat_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_dat_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
        if (rd_en_i) begin
            rd_dat_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/uart_line_editor.sv
// Line editor between UART rx and tx streams: stores/edits typed bytes, echoes keystrokes,
// and on CR emits the line as a tlast-terminated packet. Input stalls during echo and dump.
module uart_line_editor
    import uart_line_editor_pkg::*;
#(
    parameter int MAX_LEN     = 64,
    parameter int ECHO_ENABLE = 1,
    localparam int LW = $clog2(MAX_LEN + 1),
    localparam int AW = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    input_axis_tdata,
    input  logic          input_axis_tvalid,
    output logic          input_axis_tready,
    output logic [7:0]    echo_axis_tdata,
    output logic          echo_axis_tvalid,
    input  logic          echo_axis_tready,
    output logic [7:0]    output_axis_tdata,
    output logic          output_axis_tvalid,
    input  logic          output_axis_tready,
    output logic          output_axis_tlast,
    output logic          overflow,
    output logic [LW-1:0] line_len
);

    localparam bit            ECHO_ON   = (ECHO_ENABLE != 0);
    localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

    state_e        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    echo_dat_q, echo_dat_d;
    logic          ovf_q, ovf_d;
    logic          out_vld_q, out_vld_d;
    logic          out_last_q, out_last_d;
    logic          wr_en, rd_en;
    logic [7:0]    ram_dat;

    uart_line_ram #(.DEPTH(MAX_LEN), .AW(AW)) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (len_q[AW-1:0]),
        .wr_dat_i  (input_axis_tdata),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_dat_o  (ram_dat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_EDIT;
            len_q      <= '0;
            rd_ptr_q   <= '0;
            echo_dat_q <= '0;
            ovf_q      <= 1'b0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_ptr_q   <= rd_ptr_d;
            echo_dat_q <= echo_dat_d;
            ovf_q      <= ovf_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rd_ptr_d   = rd_ptr_q;
        echo_dat_d = echo_dat_q;
        ovf_d      = 1'b0;
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        case (state_q)
            ST_EDIT: begin
                if (input_axis_tvalid) begin
                    if (is_printable(input_axis_tdata)) begin
                        if (len_q < MAX_LEN_L) begin
                            wr_en      = 1'b1;
                            len_d      = len_q + LW'(1);
                            echo_dat_d = input_axis_tdata;
                        end else begin
                            ovf_d      = 1'b1;
                            echo_dat_d = CHAR_BEL;
                        end
                        state_d = ECHO_ON ? ST_ECHO : ST_EDIT;
                    end else if (input_axis_tdata == CHAR_BS || input_axis_tdata == CHAR_DEL) begin
                        if (len_q != '0) begin
                            len_d      = len_q - LW'(1);
                            echo_dat_d = CHAR_BS;
                            state_d    = ECHO_ON ? ST_ECHO_BS1 : ST_EDIT;
                        end
                    end else if (input_axis_tdata == CHAR_CR) begin
                        echo_dat_d = CHAR_CR;
                        state_d    = ECHO_ON ? ST_ECHO_CR : ST_DUMP;
                    end
                end
            end
            ST_ECHO, ST_ECHO_BS3: begin
                if (echo_axis_tready) begin
                    echo_dat_d = '0;
                    state_d    = ST_EDIT;
                end
            end
            ST_ECHO_BS1: begin
                if (echo_axis_tready) begin
                    echo_dat_d = CHAR_SP;
                    state_d    = ST_ECHO_BS2;
                end
            end
            ST_ECHO_BS2: begin
                if (echo_axis_tready) begin
                    echo_dat_d = CHAR_BS;
                    state_d    = ST_ECHO_BS3;
                end
            end
            ST_ECHO_CR: begin
                if (echo_axis_tready) begin
                    echo_dat_d = CHAR_LF;
                    state_d    = ST_ECHO_LF;
                end
            end
            ST_ECHO_LF: begin
                if (echo_axis_tready) begin
                    echo_dat_d = '0;
                    state_d    = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (len_q == '0) begin
                    state_d = ST_EDIT;
                end else begin
                    // Fetch the next byte whenever the output register is empty or draining.
                    if ((!out_vld_q || output_axis_tready) && (rd_ptr_q < len_q)) begin
                        rd_en      = 1'b1;
                        rd_ptr_d   = rd_ptr_q + LW'(1);
                        out_vld_d  = 1'b1;
                        out_last_d = (rd_ptr_q == len_q - LW'(1));
                    end
                    if (out_vld_q && output_axis_tready && out_last_q) begin
                        out_vld_d  = 1'b0;
                        out_last_d = 1'b0;
                        rd_ptr_d   = '0;
                        len_d      = '0;
                        state_d    = ST_EDIT;
                    end
                end
            end
            default: state_d = ST_EDIT;
        endcase
    end

    assign input_axis_tready  = rst_n && (state_q == ST_EDIT);
    assign echo_axis_tvalid   = ECHO_ON && (state_q inside {ST_ECHO, ST_ECHO_BS1, ST_ECHO_BS2,
                                                           ST_ECHO_BS3, ST_ECHO_CR, ST_ECHO_LF});
    assign echo_axis_tdata    = ECHO_ON ? echo_dat_q : 8'h00;
    assign output_axis_tvalid = out_vld_q;
    assign output_axis_tdata  = out_vld_q ? ram_dat : 8'h00;
    assign output_axis_tlast  = out_last_q;
    assign overflow           = ovf_q;
    assign line_len           = len_q;

endmodule

// File: tb/tb_uart_line_editor.sv
// Scoreboard bench for uart_line_editor: queue-based line model, decoupled stream monitors.
module tb_uart_line_editor;

    localparam int MAX_LEN = 4;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    in_dat;
    logic          in_vld;
    logic          in_rdy;
    logic [7:0]    echo_dat;
    logic          echo_vld;
    logic          echo_rdy;
    logic [7:0]    out_dat;
    logic          out_vld;
    logic          out_rdy;
    logic          out_last;
    logic          ovf;
    logic [LW-1:0] line_len;

    uart_line_editor #(.MAX_LEN(MAX_LEN), .ECHO_ENABLE(1)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .input_axis_tdata   (in_dat),
        .input_axis_tvalid  (in_vld),
        .input_axis_tready  (in_rdy),
        .echo_axis_tdata    (echo_dat),
        .echo_axis_tvalid   (echo_vld),
        .echo_axis_tready   (echo_rdy),
        .output_axis_tdata  (out_dat),
        .output_axis_tvalid (out_vld),
        .output_axis_tready (out_rdy),
        .output_axis_tlast  (out_last),
        .overflow           (ovf),
        .line_len           (line_len)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_echo[$];
    logic [8:0] exp_out[$];
    logic [7:0] model_line[$];
    int n_checks = 0;
    int n_fail   = 0;
    int exp_ovf  = 0;
    int seen_ovf = 0;
    int out_pops = 0;
    int rdy_mode = 0;
    logic man_echo = 1'b0;
    logic man_out  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input int act, input int exp);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: the line is a byte queue; each keystroke maps to echo bytes and, on CR, packet beats.
    task automatic model_accept(input logic [7:0] b);
        logic last;
        if (b >= 8'h20 && b <= 8'h7E) begin
            if (model_line.size() < MAX_LEN) begin
                model_line.push_back(b);
                exp_echo.push_back(b);
            end else begin
                exp_echo.push_back(8'h07);
                exp_ovf++;
            end
        end else if (b == 8'h08 || b == 8'h7F) begin
            if (model_line.size() > 0) begin
                void'(model_line.pop_back());
                exp_echo.push_back(8'h08);
                exp_echo.push_back(8'h20);
                exp_echo.push_back(8'h08);
            end
        end else if (b == 8'h0D) begin
            exp_echo.push_back(8'h0D);
            exp_echo.push_back(8'h0A);
            foreach (model_line[i]) begin
                last = (i == model_line.size() - 1);
                exp_out.push_back({last, model_line[i]});
            end
            model_line.delete();
        end
    endtask

    task automatic send(input logic [7:0] b);
        int k;
        k = 0;
        @(posedge clk);
        #1;
        in_vld = 1'b1;
        in_dat = b;
        do begin
            @(negedge clk);
            k++;
        end while (!in_rdy && k < 500);
        if (!in_rdy) begin
            fail("input_accept_timeout", k, 500);
        end else begin
            check("line_len_at_accept", 32'(line_len), 32'(model_line.size()));
            model_accept(b);
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while ((exp_echo.size() != 0 || exp_out.size() != 0 || !in_rdy) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) fail({name, "_idle_timeout"}, exp_echo.size() + exp_out.size(), 0);
        check({name, "_ovf_count"}, 32'(seen_ovf), 32'(exp_ovf));
        check({name, "_line_len"}, 32'(line_len), 32'(model_line.size()));
    endtask

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0: begin echo_rdy = 1'b1; out_rdy = 1'b1; end
            1: begin echo_rdy = ($urandom_range(0, 3) != 0); out_rdy = ($urandom_range(0, 2) != 0); end
            2: begin echo_rdy = man_echo; out_rdy = man_out; end
            default: begin echo_rdy = 1'b1; out_rdy = ~out_rdy; end
        endcase
    end

    logic [7:0] echo_hold;
    logic       echo_stall = 1'b0;
    logic [8:0] out_hold;
    logic       out_stall = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            echo_stall = 1'b0;
            out_stall  = 1'b0;
        end else begin
            if (echo_stall) check("echo_held_stable", 32'({echo_vld, echo_dat}), 32'({1'b1, echo_hold}));
            if (out_stall)  check("out_held_stable", 32'({out_vld, out_last, out_dat}), 32'({1'b1, out_hold}));
            if (echo_vld || out_vld) check("in_rdy_low_while_busy", 32'(in_rdy), 32'(0));
            if (echo_vld && echo_rdy) begin
                if (exp_echo.size() == 0) fail("echo_unexpected_byte", int'(echo_dat), -1);
                else check("echo_byte", 32'(echo_dat), 32'(exp_echo.pop_front()));
            end
            if (out_vld && out_rdy) begin
                out_pops++;
                if (exp_out.size() == 0) fail("out_unexpected_beat", int'({out_last, out_dat}), -1);
                else check("out_beat", 32'({out_last, out_dat}), 32'(exp_out.pop_front()));
            end
            echo_stall = echo_vld && !echo_rdy;
            echo_hold  = echo_dat;
            out_stall  = out_vld && !out_rdy;
            out_hold   = {out_last, out_dat};
            if (ovf) seen_ovf++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int ovf0;
        int pops0;
        int len;
        int r;
        logic [7:0] b;
        rst_n  = 1'b0;
        in_vld = 1'b0;
        in_dat = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({in_rdy, echo_vld, echo_dat, out_vld, out_dat, out_last, ovf}), 32'(0));
        check("reset_line_len", 32'(line_len), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(8'h41); send(8'h42); send(8'h0D);
        wait_idle("basic_line");

        send(8'h41); send(8'h42); send(8'h08); send(8'h43); send(8'h0D);
        wait_idle("backspace_line");

        ovf0 = seen_ovf;
        send(8'h41); send(8'h42); send(8'h43); send(8'h44); send(8'h45); send(8'h0D);
        wait_idle("overflow_line");
        check("overflow_single_pulse", 32'(seen_ovf - ovf0), 32'(1));

        send(8'h08); send(8'h0A); send(8'h0D);
        k = 0;
        while (exp_echo.size() != 0 && k < 100) begin @(negedge clk); k++; end
        k = 0;
        do begin @(negedge clk); k++; end while (!in_rdy && k < 20);
        check("empty_line_ready_within_2", 32'(k <= 2), 32'(1));
        wait_idle("empty_line");

        rdy_mode = 2; man_echo = 1'b0; man_out = 1'b1;
        send(8'h41);
        repeat (10) @(negedge clk);
        check("echo_stalled_state", 32'({echo_vld, echo_dat, in_rdy}), 32'({1'b1, 8'h41, 1'b0}));
        @(posedge clk);
        #1;
        man_echo = 1'b1;
        send(8'h0D);
        wait_idle("echo_backpressure");

        rdy_mode = 3;
        pops0 = out_pops;
        send(8'h41); send(8'h42); send(8'h43); send(8'h0D);
        wait_idle("toggle_out_ready");
        check("toggle_beat_count", 32'(out_pops - pops0), 32'(3));

        rdy_mode = 2; man_echo = 1'b1; man_out = 1'b0;
        send(8'h41); send(8'h42); send(8'h43); send(8'h0D);
        k = 0;
        do begin @(negedge clk); k++; end while (!out_vld && k < 100);
        if (!out_vld) fail("dump_start_timeout", k, 100);
        pops0 = out_pops;
        @(posedge clk);
        #1;
        man_out = 1'b1;
        @(posedge clk);
        #1;
        man_out = 1'b0;
        rst_n   = 1'b0;
        exp_out.delete();
        exp_echo.delete();
        model_line.delete();
        check("beats_before_reset", 32'(out_pops - pops0), 32'(1));
        @(posedge clk);
        @(negedge clk);
        check("mid_dump_reset_outputs", 32'({in_rdy, echo_vld, echo_dat, out_vld, out_dat, out_last, ovf}), 32'(0));
        check("mid_dump_reset_len", 32'(line_len), 32'(0));
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        rdy_mode = 0;
        send(8'h5A); send(8'h0D);
        wait_idle("after_reset_line");

        rdy_mode = 1;
        for (int line = 0; line < 40; line++) begin
            len = $urandom_range(0, 7);
            for (int c = 0; c < len; c++) begin
                r = $urandom_range(0, 99);
                if (r < 65) begin
                    b = 8'($urandom_range(8'h20, 8'h7E));
                end else if (r < 82) begin
                    b = ($urandom_range(0, 1) == 0) ? 8'h08 : 8'h7F;
                end else begin
                    do b = 8'($urandom_range(0, 255));
                    while ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 || b == 8'h7F || b == 8'h0D);
                end
                send(b);
            end
            send(8'h0D);
            wait_idle("random_line");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_line_editor.md
Name: uart_line_editor

Overview:
- Sits between the UART receive AXI stream and the UART transmit AXI stream.
- Turns raw typed bytes into edited command lines: it stores printable characters, handles backspace, and echoes each keystroke back to the terminal on the transmit stream.
- On carriage return it emits the completed line as a packet on an output AXI stream with tlast, for a downstream command decoder.

Parameters:
- MAX_LEN, 64: line buffer depth in bytes, range 2..256.
- ECHO_ENABLE, 1: 1 = echo stream is active; 0 = echo_axis_tvalid is tied low and no echo states are entered.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- input_axis_tdata  in  8  received byte from the UART receiver.
- input_axis_tvalid  in  1  received byte valid.
- input_axis_tready  out  1  accept; high only in EDIT.
- echo_axis_tdata  out  8  byte to the UART transmitter.
- echo_axis_tvalid  out  1  echo byte valid.
- echo_axis_tready  in  1  transmitter accepts.
- output_axis_tdata  out  8  line byte.
- output_axis_tvalid  out  1  line byte valid.
- output_axis_tready  in  1  consumer accepts.
- output_axis_tlast  out  1  last byte of line.
- overflow  out  1  one-cycle pulse when a printable byte is dropped because the buffer is full.
- line_len  out  clog2(MAX_LEN+1)  current stored byte count.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All outputs go to 0; line_len goes to 0; state goes to EDIT.
  - Buffer contents are don't-care.
  - Reset aborts any echo or dump in progress; partial packets are not completed.
- States: EDIT, ECHO, ECHO_BS1, ECHO_BS2, ECHO_BS3, ECHO_CR, ECHO_LF, DUMP.
- EDIT:
  - input_axis_tready = 1. A byte is accepted on tvalid&&tready and classified in the same cycle.
- Printable byte (0x20..0x7E):
  - If line_len < MAX_LEN: write buf[line_len], increment line_len, load echo = byte, go to ECHO.
  - Otherwise: drop the byte, pulse overflow, load echo = 0x07 (BEL), go to ECHO.
- BS (0x08) or DEL (0x7F):
  - If line_len > 0: decrement line_len, go to ECHO_BS1. The echo sequence is 0x08, 0x20, 0x08.
  - If line_len = 0: ignore the byte, no echo, stay in EDIT.
- CR (0x0D): go to ECHO_CR. The echo sequence is 0x0D, 0x0A; then go to DUMP.
- LF (0x0A) and all other bytes (0x00..0x1F except those above, 0x80..0xFF): silently ignored, stay in EDIT.
- Echo states:
  - echo_axis_tvalid = 1 with a registered, stable tdata until echo_axis_tready.
  - On the handshake, advance to the next echo state. ECHO and ECHO_BS3 return to EDIT; ECHO_LF goes to DUMP.
  - input_axis_tready = 0 throughout.
- ECHO_ENABLE = 0: every echo state is bypassed with zero cycles. An accepted byte goes directly to EDIT, or to DUMP for CR.
- DUMP:
  - If line_len = 0 on entry: emit no beat and return to EDIT the next cycle.
  - Otherwise: stream buf[0..line_len-1] in order; output_axis_tlast = 1 on index line_len-1.
  - The buffer is read synchronously. The first beat is valid 1 cycle after entering DUMP, and beats are back-to-back while tready is high.
  - tdata, tvalid and tlast are held stable while tready is low.
  - After the tlast handshake: line_len = 0, state = EDIT, output_axis_tvalid = 0 in the following cycle.
- line_len arithmetic: never exceeds MAX_LEN and never wraps below 0.
- Throughput: at most one input byte per echo completion. Input stalls during echo and dump.

Decomposition:
- Shared package: character constants CHAR_BS=0x08, CHAR_DEL=0x7F, CHAR_CR=0x0D, CHAR_LF=0x0A, CHAR_SP=0x20, CHAR_BEL=0x07, and the state encoding.
- Sub-module uart_line_ram:
  - MAX_LEN x 8 simple dual-port RAM.
  - One write port; one read port with a registered read.
  - Infers block or distributed RAM.

Test Plan:
- Bytes 41,42,0D with tready always high -> echo 41,42,0D,0A; output 41,42 with tlast on 42; line_len returns to 0.
- Bytes 41,42,08,43,0D -> echo 41,42,08,20,08,43,0D,0A; output 41,43 with tlast on 43.
- MAX_LEN=4, bytes 41,42,43,44,45,0D -> fifth byte echoed as 07 with one overflow pulse; output 41,42,43,44 with tlast on 44.
- Bytes 08,0A,0D on an empty line -> no echo for 08 or 0A; echo 0D,0A; zero output beats; input_axis_tready high again within 2 cycles.
- Backpressure:
  - Hold echo_axis_tready low for 10 cycles -> echo data stable and input_axis_tready low.
  - Toggle output_axis_tready during the dump of "ABC" -> beats 41,42,43 delivered exactly once each, in order.
- Assert rst_n low mid-dump after the first beat -> all outputs 0 next cycle; new line "Z\r" then yields output 5A with tlast.
